// File: rtl/range_session_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : range_pkg                                                       |
// | Purpose  : Shared types and constants for the range-finder session         |
// |            controller and its round-robin arbiter.                         |
// | Contents : state_e  - controller FSM states                                |
// |            result_t - {id, range, error} result record                     |
// |            RANGE_WIDTH - default sample/range width                        |
// |            idw()    - index width for an N-wide one-hot vector             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package range_pkg;

  localparam int RANGE_WIDTH = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FIRST   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DUP     = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_RESULT  = 3'd5
  } state_e;

  typedef struct packed {
    logic [7:0]             id;
    logic [RANGE_WIDTH-1:0] range;
    logic                   error;
  } result_t;

  // Width of an index into an n-entry vector; never zero so ports stay legal
  // for a single requester.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : range_pkg
`default_nettype wire

// File: rtl/range_session_ctrl_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arbiter                                                      |
// | Purpose  : NREQ-wide round-robin picker. The search starts at the          |
// |            requester after the last winner; priority resets to 0.          |
// | Ports    : i_clk, i_rst      clock, async active-high reset                 |
// |            i_req             request vector                                |
// |            i_advance         move priority past the current owner          |
// |            i_grant           current owner (one-hot), used on advance      |
// |            o_grant_next      one-hot pick for the present requests         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module rr_arbiter
  import range_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_advance,
  input  logic [NREQ-1:0] i_grant,
  output logic [NREQ-1:0] o_grant_next
);

  localparam int IDW = idw(NREQ);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_win_idx;
  logic [IDW-1:0] w_ptr_nxt;

  // Scan requesters starting at r_ptr, wrapping once around.
  always_comb begin : p_pick
    int   idx;
    logic found;
    o_grant_next = '0;
    found        = 1'b0;
    idx          = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && i_req[IDW'(idx)]) begin
        o_grant_next[IDW'(idx)] = 1'b1;
        found                   = 1'b1;
      end
    end
  end

  always_comb begin : p_win_idx
    w_win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (i_grant[k]) w_win_idx = IDW'(k);
    end
  end

  assign w_ptr_nxt = (int'(w_win_idx) == NREQ - 1) ? '0 : w_win_idx + IDW'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/range_session_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : range_session_ctrl                                              |
// | Purpose  : Shares one range-finder datapath among NREQ sample streams.     |
// |            Grants one requester per session, turns its valid/last stream   |
// |            into go/finish strobes and returns the captured range.          |
// | Ports    : i_clk, i_rst            clock, async active-high reset          |
// |            i_req                   per-requester session request           |
// |            o_grant                 one-hot session owner                   |
// |            i_s_data/valid/last     per-requester sample streams            |
// |            o_s_ready               accept strobe (owner only)              |
// |            o_rf_data/go/finish     registered range-finder drive           |
// |            i_rf_range, i_rf_error  range-finder result                     |
// |            o_res_valid/id/range/error  result to the session owner         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module range_session_ctrl
  import range_pkg::*;
#(
  parameter int WIDTH   = RANGE_WIDTH,
  parameter int NREQ    = 2,
  parameter int MAX_GAP = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req,
  output logic [NREQ-1:0]       o_grant,
  input  logic [NREQ*WIDTH-1:0] i_s_data,
  input  logic [NREQ-1:0]       i_s_valid,
  input  logic [NREQ-1:0]       i_s_last,
  output logic [NREQ-1:0]       o_s_ready,
  output logic [WIDTH-1:0]      o_rf_data,
  output logic                  o_rf_go,
  output logic                  o_rf_finish,
  input  logic [WIDTH-1:0]      i_rf_range,
  input  logic                  i_rf_error,
  output logic                  o_res_valid,
  output logic [idw(NREQ)-1:0]  o_res_id,
  output logic [WIDTH-1:0]      o_res_range,
  output logic                  o_res_error
);

  localparam int IDW = idw(NREQ);
  localparam int GW  = $clog2(MAX_GAP + 1);
  localparam logic [GW-1:0] C_GAP_LAST = GW'(MAX_GAP - 1);

  state_e          r_state, w_state_nxt;
  logic [NREQ-1:0] r_grant, w_grant_nxt, w_arb_grant, w_s_ready;
  logic [IDW-1:0]  r_gidx, w_gidx_nxt, w_arb_idx, r_res_id;
  logic [WIDTH-1:0] r_rf_data, w_rf_data_nxt, w_sample, r_res_range;
  logic            r_rf_go, w_go_nxt;
  logic            r_rf_finish, w_fin_nxt;
  logic            r_abort, w_abort_nxt;
  logic            r_res_error, w_capture;
  logic [GW-1:0]   r_gap, w_gap_nxt;
  logic            w_acc, w_last;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req        (i_req),
    .i_advance    (r_state == ST_RESULT),
    .i_grant      (r_grant),
    .o_grant_next (w_arb_grant)
  );

  always_comb begin : p_arb_idx
    w_arb_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_arb_grant[k]) w_arb_idx = IDW'(k);
    end
  end

  // Ready depends only on state and owner so a source may gate valid on it.
  assign w_s_ready = ((r_state == ST_FIRST) || (r_state == ST_RUN)) ? r_grant : '0;
  assign w_acc     = |(i_s_valid & w_s_ready);
  assign w_last    = |(i_s_valid & i_s_last & w_s_ready);
  assign w_sample  = i_s_data[int'(r_gidx)*WIDTH +: WIDTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin : p_next
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_gidx_nxt    = r_gidx;
    w_rf_data_nxt = r_rf_data;
    w_go_nxt      = 1'b0;
    w_fin_nxt     = 1'b0;
    w_gap_nxt     = r_gap;
    w_abort_nxt   = r_abort;
    w_capture     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_gap_nxt   = '0;
        w_abort_nxt = 1'b0;
        if (|i_req) begin
          w_grant_nxt = w_arb_grant;
          w_gidx_nxt  = w_arb_idx;
          w_state_nxt = ST_FIRST;
        end
      end
      ST_FIRST: begin
        if (w_acc) begin
          w_go_nxt      = 1'b1;
          w_rf_data_nxt = w_sample;
          w_gap_nxt     = '0;
          w_state_nxt   = w_last ? ST_DUP : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_acc) begin
          w_rf_data_nxt = w_sample;
          w_gap_nxt     = '0;
          if (w_last) begin
            w_fin_nxt   = 1'b1;
            w_state_nxt = ST_CAPTURE;
          end
        end else if (r_gap == C_GAP_LAST) begin
          // Stream went quiet too long: close on the held sample.
          w_fin_nxt   = 1'b1;
          w_abort_nxt = 1'b1;
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_gap_nxt = r_gap + GW'(1);
        end
      end
      ST_DUP: begin
        // Repeat the lone sample with finish so go and finish never overlap.
        w_fin_nxt   = 1'b1;
        w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // The result is valid the cycle after finish, so wait out the
        // cycle in which finish is still being driven.
        if (!r_rf_finish) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESULT;
        end
      end
      ST_RESULT: begin
        w_grant_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_grant     <= '0;
      r_gidx      <= '0;
      r_rf_data   <= '0;
      r_rf_go     <= 1'b0;
      r_rf_finish <= 1'b0;
      r_gap       <= '0;
      r_abort     <= 1'b0;
      r_res_range <= '0;
      r_res_error <= 1'b0;
      r_res_id    <= '0;
    end else begin
      r_grant     <= w_grant_nxt;
      r_gidx      <= w_gidx_nxt;
      r_rf_data   <= w_rf_data_nxt;
      r_rf_go     <= w_go_nxt;
      r_rf_finish <= w_fin_nxt;
      r_gap       <= w_gap_nxt;
      r_abort     <= w_abort_nxt;
      if (w_capture) begin
        r_res_range <= i_rf_range;
        r_res_error <= i_rf_error | r_abort;
        r_res_id    <= r_gidx;
      end
    end
  end

  assign o_grant     = r_grant;
  assign o_s_ready   = w_s_ready;
  assign o_rf_data   = r_rf_data;
  assign o_rf_go     = r_rf_go;
  assign o_rf_finish = r_rf_finish;
  assign o_res_valid = (r_state == ST_RESULT);
  assign o_res_id    = r_res_id;
  assign o_res_range = r_res_range;
  assign o_res_error = r_res_error;

endmodule : range_session_ctrl
`default_nettype wire

// File: tb/tb_range_session_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_range_session_ctrl                                           |
// | Purpose  : Self-checking bench for range_session_ctrl with a behavioural   |
// |            range finder (max-min over go..finish) and a result scoreboard. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_range_session_ctrl;

  localparam int W = 10;
  localparam int N = 2;
  localparam int G = 15;

  logic           clk, rst;
  logic [N-1:0]   req, grant, s_valid, s_last, s_ready;
  logic [N*W-1:0] s_data;
  logic [W-1:0]   rf_data, rf_range, res_range;
  logic           rf_go, rf_finish, rf_error, res_valid, res_error;
  logic [0:0]     res_id;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int tb_ptr   = 0;

  typedef struct {
    int id;
    int rng;
    bit err;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  range_session_ctrl #(.WIDTH(W), .NREQ(N), .MAX_GAP(G)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_grant(grant),
    .i_s_data(s_data), .i_s_valid(s_valid), .i_s_last(s_last), .o_s_ready(s_ready),
    .o_rf_data(rf_data), .o_rf_go(rf_go), .o_rf_finish(rf_finish),
    .i_rf_range(rf_range), .i_rf_error(rf_error),
    .o_res_valid(res_valid), .o_res_id(res_id), .o_res_range(res_range),
    .o_res_error(res_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural range finder: tracks min/max from go through finish.
  logic [W-1:0] mn, mx, go_data, fin_data, ovr_val;
  bit act, ovr_en;
  int go_cyc = -100, fin_cyc = -100;

  always @(negedge clk) begin
    if (rst) begin
      act      = 1'b0;
      rf_range = '0;
    end else begin
      if (rf_go || rf_finish) begin
        n_checks++;
        if (rf_go && rf_finish)
          $display("FAIL go_finish_overlap cyc=%0d got go=%b finish=%b want not both", cyc, rf_go, rf_finish);
        else n_pass++;
      end
      if (rf_go) begin
        act = 1'b1; mn = rf_data; mx = rf_data; go_data = rf_data; go_cyc = cyc;
      end else if (act) begin
        if (rf_data < mn) mn = rf_data;
        if (rf_data > mx) mx = rf_data;
      end
      if (rf_finish) begin
        fin_data = rf_data; fin_cyc = cyc; act = 1'b0;
        rf_range = ovr_en ? ovr_val : (mx - mn);
      end
    end
  end

  // Scoreboard: each result must match the oldest expectation, two cycles
  // after finish.
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      n_checks++;
      if (sbq.size() == 0) begin
        $display("FAIL result_unexpected got id=%0d range=%0d want no result", res_id, res_range);
      end else begin
        e = sbq.pop_front();
        if (int'(res_id) != e.id || int'(res_range) != e.rng || res_error !== e.err || cyc != fin_cyc + 2)
          $display("FAIL result got id=%0d range=%0d err=%b at finish+%0d want id=%0d range=%0d err=%b at finish+2",
                   res_id, res_range, res_error, cyc - fin_cyc, e.id, e.rng, e.err);
        else n_pass++;
      end
    end
  end

  task automatic start_grant(input logic [N-1:0] r, input logic [N-1:0] want);
    @(negedge clk);
    req = r;
    @(negedge clk);
    n_checks++;
    if (grant !== want) $display("FAIL grant_latency got %b want %b", grant, want);
    else n_pass++;
    req = '0;
  endtask

  task automatic send(input int id, input int v, input bit last);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    s_data[id*W +: W] = W'(v);
    s_valid[id] = 1'b1;
    s_last[id]  = last;
    for (int k = 0; k < 200; k++) begin
      if (s_ready[id]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) $display("FAIL send_timeout id=%0d got ready=0 want 1", id);
    else begin
      n_pass++;
      @(posedge clk);
    end
    #1;
    s_valid[id] = 1'b0;
    s_last[id]  = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sbq.size() == 0 && grant === '0) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) $display("FAIL done_timeout got pending=%0d grant=%b want 0 and 00", sbq.size(), grant);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; s_valid = '0; s_last = '0; s_data = '0;
    rf_error = 1'b0; ovr_en = 1'b0; ovr_val = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({grant, s_ready} !== '0) $display("FAIL reset_grant got %b_%b want 0", grant, s_ready);
    else n_pass++;
    n_checks++;
    if ({rf_go, rf_finish, rf_data} !== '0) $display("FAIL reset_rf got go=%b fin=%b data=%0d want 0", rf_go, rf_finish, rf_data);
    else n_pass++;
    n_checks++;
    if ({res_valid, res_id, res_range, res_error} !== '0)
      $display("FAIL reset_res got v=%b id=%0d r=%0d e=%b want 0", res_valid, res_id, res_range, res_error);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    ovr_en = 1'b1; ovr_val = W'(863);
    start_grant(2'b01, 2'b01);
    sbq.push_back('{0, 863, 1'b0});
    send(0, 5, 1'b0); send(0, 900, 1'b0); send(0, 37, 1'b1);
    wait_done();
    ovr_en = 1'b0;
    n_checks++;
    if (go_data !== W'(5) || fin_data !== W'(37))
      $display("FAIL basic_go_fin got go=%0d fin=%0d want 5 37", go_data, fin_data);
    else n_pass++;
    n_checks++;
    if (fin_cyc - go_cyc != 2) $display("FAIL basic_throughput got span=%0d want 2", fin_cyc - go_cyc);
    else n_pass++;
    tb_ptr = 1;
  endtask

  task automatic test_single();
    rf_error = 1'b1;
    start_grant(2'b01, 2'b01);
    sbq.push_back('{0, 0, 1'b1});
    send(0, 412, 1'b1);
    wait_done();
    rf_error = 1'b0;
    n_checks++;
    if (go_data !== W'(412) || fin_data !== W'(412) || fin_cyc != go_cyc + 1)
      $display("FAIL single got go=%0d fin=%0d span=%0d want 412 412 1", go_data, fin_data, fin_cyc - go_cyc);
    else n_pass++;
  endtask

  task automatic test_gap();
    start_grant(2'b01, 2'b01);
    sbq.push_back('{0, 97, 1'b0});
    send(0, 100, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (rf_data !== W'(100) || rf_finish !== 1'b0)
        $display("FAIL gap_hold got data=%0d fin=%b want 100 0", rf_data, rf_finish);
      else n_pass++;
    end
    send(0, 3, 1'b1);
    wait_done();
  endtask

  task automatic test_abort();
    int acc;
    start_grant(2'b01, 2'b01);
    sbq.push_back('{0, 0, 1'b1});
    send(0, 50, 1'b0);
    acc = cyc;
    wait_done();
    n_checks++;
    if (fin_data !== W'(50) || fin_cyc != acc + G)
      $display("FAIL abort_finish got data=%0d at +%0d want 50 at +%0d", fin_data, fin_cyc - acc, G);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int w, low, a, b;
    @(negedge clk);
    req = 2'b11;
    w = tb_ptr;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 20; k++) begin
        if (grant !== '0) break;
        @(negedge clk);
      end
      n_checks++;
      if (grant !== N'(1 << w)) $display("FAIL rr_order session=%0d got %b want %b", s, grant, N'(1 << w));
      else n_pass++;
      if (s == 3) req = '0;
      a = 10 + s; b = 200 + 7 * s;
      sbq.push_back('{w, b - a, 1'b0});
      send(w, a, 1'b0); send(w, b, 1'b0); send(w, 60, 1'b1);
      w = 1 - w;
      if (s < 3) begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (grant === '0) break;
        end
        low = 0;
        while (grant === '0 && low < 20) begin
          low++;
          @(negedge clk);
        end
        n_checks++;
        if (low != 1) $display("FAIL grant_gap got %0d low cycles want 1", low);
        else n_pass++;
      end
    end
    tb_ptr = w;
    wait_done();
  endtask

  task automatic test_reset_mid();
    start_grant(2'b01, 2'b01);
    send(0, 77, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({grant, s_ready, rf_go, rf_finish, rf_data, res_valid, res_id, res_range, res_error} !== '0)
      $display("FAIL async_reset got grant=%b go=%b fin=%b data=%0d res_v=%b want all 0", grant, rf_go, rf_finish, rf_data, res_valid);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    start_grant(2'b11, 2'b01);
    sbq.push_back('{0, 0, 1'b0});
    send(0, 5, 1'b1);
    wait_done();
    start_grant(2'b10, 2'b10);
    sbq.push_back('{1, 0, 1'b0});
    send(1, 9, 1'b1);
    wait_done();
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_basic();
    test_single();
    test_gap();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (sbq.size() != 0) $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_range_session_ctrl
`default_nettype wire
